mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer for an N×N systolic array of `mac_cell` instances. It accepts a matrix-multiply job, clears the accumulators, and streams K operand indices to the operand buffers and skew registers. It then holds the array enabled until the last partial products have propagated, and signals completion. It sits between the job/command interface and the array datapath. It drives the array's shared `shift_en`, `acc_en` and `acc_rst`, plus the buffers' read port.

## Interface
- `N`, default 4: array dimension (rows = columns).
- `K_WIDTH`, default 8: width of reduction-length field; max K = 2^K_WIDTH − 1.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `start` in, 1: job request; sampled only in IDLE.
- `k_len` in, K_WIDTH: reduction length K; latched when `start` is accepted.
- `stall` in, 1: freeze request from operand buffers (see Configuration).
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse; array `acc_out` values are final.
- `acc_rst` out, 1: to all cells; clears accumulators.
- `shift_en` out, 1: to all cells.
- `acc_en` out, 1: to all cells.
- `rd_en` out, 1: operand buffer read strobe.
- `rd_addr` out, K_WIDTH: reduction index k for the current read.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - All outputs 0.
  - `start`=1 latches `k_len` into `k_reg` and moves to CLEAR. `start` in any other state is ignored.
- CLEAR: exactly 1 cycle with `acc_rst`=1.
  - Next state is FEED if `k_reg`≠0.
  - Next state is DONE if `k_reg`=0, so accumulators stay 0.
- FEED: `k_reg` cycles.
  - `rd_en`=`shift_en`=`acc_en`=1.
  - `rd_addr` counts 0,1,…,`k_reg`−1.
  - Moves to DRAIN after the cycle with `rd_addr`=`k_reg`−1.
- DRAIN: 2N−1 cycles.
  - `shift_en`=`acc_en`=1, `rd_en`=0, `rd_addr` holds at 0.
  - The external skew registers feed zeros during DRAIN.
  - The drain counter is ⌈log2(2N)⌉ bits wide.
- DONE: 1 cycle with `done`=1 and `busy`=1, then IDLE.
  - A `start` in this cycle is ignored; it is honored in the following IDLE cycle.
- Width rule: `rd_addr` never wraps. The FEED counter compares against `k_reg`−1, so K = 2^K_WIDTH−1 is legal.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset: state=IDLE, counters 0, `k_reg`=0, and every output 0.
  - Reset asserted mid-job aborts immediately and asynchronously. After release, a new `start` is required.
- Let edge 1 be the edge that samples `start`. Without stall:
  - CLEAR after edge 1.
  - FEED after edges 2..K+1.
  - DRAIN after edges K+2..K+2N.
  - `done` high after edge K+2N+1.
- Job latency is therefore K+2N+1 cycles. Back-to-back jobs have a minimum spacing of K+2N+2 cycles.
- `busy` rises after edge 1 and falls after the edge following `done`.

## Configuration
- Macro: `MAC_SEQ_STALL_EN`.
- Defined:
  - `stall`=1 in FEED or DRAIN forces `shift_en`, `acc_en` and `rd_en` to 0 in the following cycle.
  - The FEED counter, DRAIN counter and `rd_addr` freeze, and the state does not advance.
  - Deasserting `stall` resumes at the same index.
  - `stall` is ignored in IDLE, CLEAR and DONE.
  - Latency grows by exactly the number of stalled FEED/DRAIN cycles.
- Undefined: the `stall` port exists but is unused. Behavior is identical to `stall`=0.

## Test plan
- Reset: `rst`=1 mid-FEED (N=4, K=3) → all outputs 0 immediately, state IDLE. The next `start` runs a full 12-cycle job.
- Nominal, N=4, K=3: `start` pulse →
  - `acc_rst` for 1 cycle.
  - `rd_addr` 0,1,2 with `rd_en`=1.
  - 7 DRAIN cycles.
  - `done` 12 edges after the sampling edge.
  - With a 1×1 cell fed (2,3),(4,1),(6,−1), the cell `acc_out`=4.
- K=0: `start` with `k_len`=0 → CLEAR, then DONE, so `done` after edge 2. `shift_en`, `acc_en` and `rd_en` never assert.
- Max K, with K_WIDTH=4 and K=15 → `rd_addr` runs 0..15−1 with no wrap. `done` after edge 15+2N+1.
- Start during busy: `start` held high through a K=2 job → exactly one job runs. A second job begins the cycle after `done` falls.
- Stall (`MAC_SEQ_STALL_EN`): K=3 with `stall`=1 for 2 cycles at `rd_addr`=1 → `rd_addr` sequence 0,1,(hold),1,2. `done` arrives 2 cycles later than nominal. Without the macro, the same stimulus gives nominal timing.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for an NxN systolic MAC array.
// Optional operand-buffer stall support: define MAC_SEQ_STALL_EN.
module mac_seq_ctrl #(
  parameter int N       = 4,
  parameter int K_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_len,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               acc_rst,
  output logic               shift_en,
  output logic               acc_en,
  output logic               rd_en,
  output logic [K_WIDTH-1:0] rd_addr
);

  localparam int DW = $clog2(2 * N);
  localparam logic [DW-1:0] DR_LAST = DW'(2 * N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [K_WIDTH-1:0] k_reg, k_nxt;
  logic [K_WIDTH-1:0] addr_nxt;
  logic [DW-1:0]      dcnt, dcnt_nxt;
  logic               stall_act;
  logic               hold;
  logic               busy_nxt, done_nxt, acc_rst_nxt;
  logic               shift_en_nxt, acc_en_nxt, rd_en_nxt;

`ifdef MAC_SEQ_STALL_EN
  assign stall_act = stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_act    = 1'b0;
`endif

  // A stall only freezes the streaming phases.
  assign hold = stall_act &&
                (state == S_FEED || state == S_DRAIN);

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k_reg    <= '0;
      dcnt     <= '0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_rst  <= 1'b0;
      shift_en <= 1'b0;
      acc_en   <= 1'b0;
      rd_en    <= 1'b0;
    end else begin
      state    <= state_nxt;
      k_reg    <= k_nxt;
      dcnt     <= dcnt_nxt;
      rd_addr  <= addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      acc_rst  <= acc_rst_nxt;
      shift_en <= shift_en_nxt;
      acc_en   <= acc_en_nxt;
      rd_en    <= rd_en_nxt;
    end
  end

  // Next state; rd_addr doubles as the FEED index counter.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_reg;
    addr_nxt  = rd_addr;
    dcnt_nxt  = dcnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CLEAR;
          k_nxt     = k_len;
        end
      end
      S_CLEAR: begin
        addr_nxt  = '0;
        dcnt_nxt  = '0;
        state_nxt = (k_reg == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (!hold) begin
          if (rd_addr == k_reg - 1'b1) begin
            state_nxt = S_DRAIN;
            addr_nxt  = '0;
          end else begin
            addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!hold) begin
          if (dcnt == DR_LAST) begin
            state_nxt = S_DONE;
            dcnt_nxt  = '0;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, from the next state.
  always_comb begin
    busy_nxt     = (state_nxt != S_IDLE);
    done_nxt     = (state_nxt == S_DONE);
    acc_rst_nxt  = (state_nxt == S_CLEAR);
    shift_en_nxt = 1'b0;
    acc_en_nxt   = 1'b0;
    rd_en_nxt    = 1'b0;
    if (!hold) begin
      shift_en_nxt = (state_nxt == S_FEED) ||
                     (state_nxt == S_DRAIN);
      acc_en_nxt   = shift_en_nxt;
      rd_en_nxt    = (state_nxt == S_FEED);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl.
// N=4, K_WIDTH=4; outputs sampled 1ns after each rising edge.
module tb_mac_seq_ctrl;

  localparam int N  = 4;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          stall;
  logic          busy, done, acc_rst;
  logic          shift_en, acc_en, rd_en;
  logic [KW-1:0] rd_addr;

  int checks = 0;
  int errors = 0;

  int op_a [0:15];
  int op_b [0:15];
  int acc;

  mac_seq_ctrl #(.N(N), .K_WIDTH(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .acc_rst  (acc_rst),
    .shift_en (shift_en),
    .acc_en   (acc_en),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr)
  );

  always #5 clk = ~clk;

  // 1x1 cell reference fed straight from the operand tables.
  always @(posedge clk or posedge rst) begin
    if (rst)
      acc <= 0;
    else if (acc_rst)
      acc <= 0;
    else if (acc_en && rd_en)
      acc <= acc + op_a[rd_addr] * op_b[rd_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KW+5:0] outs();
    return {busy, done, acc_rst, shift_en,
            acc_en, rd_en, rd_addr};
  endfunction

  // Expected outputs c edges after the start-sampling edge.
  function automatic logic [KW+5:0] exp_at(input int k,
                                           input int c);
    int last;
    last = (k == 0) ? 2 : k + 2 * N + 1;
    if (c == 1)
      return {6'b101000, KW'(0)};
    else if (k != 0 && c >= 2 && c <= k + 1)
      return {6'b100111, KW'(c - 2)};
    else if (k != 0 && c >= k + 2 && c <= k + 2 * N)
      return {6'b100110, KW'(0)};
    else if (c == last)
      return {6'b110000, KW'(0)};
    return '0;
  endfunction

  task automatic test_reset;
    logic [KW+5:0] e;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", outs(), '0);
    end
    rst = 1'b0;
    k_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== {6'b100111, KW'(1)}) begin
      errors++;
      $display("FAIL pre_abort got %h exp %h",
               outs(), {6'b100111, KW'(1)});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL async_abort got %h exp %h", outs(), '0);
    end
    #1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL idle_after_abort got %h exp %h",
               outs(), '0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3 + 2 * N + 2; c++) begin
      if (c > 1) tick();
      e = exp_at(3, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL rerun c=%0d got %h exp %h",
                 c, outs(), e);
      end
    end
  endtask

  task automatic test_nominal;
    logic [KW+5:0] e;
    op_a[0] = 2; op_b[0] = 3;
    op_a[1] = 4; op_b[1] = 1;
    op_a[2] = 6; op_b[2] = -1;
    k_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3 + 2 * N + 2; c++) begin
      if (c > 1) tick();
      e = exp_at(3, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL nominal c=%0d got %h exp %h",
                 c, outs(), e);
      end
      if (c == 12) begin
        checks++;
        if (acc !== 4) begin
          errors++;
          $display("FAIL cell_acc got %0d exp 4", acc);
        end
      end
    end
  endtask

  task automatic test_k_zero;
    logic [KW+5:0] e;
    k_len = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      e = exp_at(0, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL k_zero c=%0d got %h exp %h",
                 c, outs(), e);
      end
    end
  endtask

  task automatic test_max_k;
    logic [KW+5:0] e;
    k_len = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15 + 2 * N + 2; c++) begin
      if (c > 1) tick();
      e = exp_at(15, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL max_k c=%0d got %h exp %h",
                 c, outs(), e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [KW+5:0] e;
    int n;
    k_len = 4'd2;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 2 + 2 * N + 3; c++) begin
      if (c > 1) tick();
      if (c == 2 + 2 * N + 3)
        e = {6'b101000, KW'(0)};
      else
        e = exp_at(2, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL held_start c=%0d got %h exp %h",
                 c, outs(), e);
      end
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL second_job_end got busy=%b exp 0", busy);
    end
    tick();
  endtask

  task automatic test_stall;
    logic [KW+5:0] e;
    int sh;
`ifdef MAC_SEQ_STALL_EN
    sh = 2;
`else
    sh = 0;
`endif
    k_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3 + 2 * N + 2 + sh; c++) begin
      if (c > 1) tick();
      if (sh != 0 && (c == 4 || c == 5))
        e = {6'b100000, KW'(1)};
      else if (sh != 0 && c >= 6)
        e = exp_at(3, c - sh);
      else
        e = exp_at(3, c);
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL stall c=%0d got %h exp %h",
                 c, outs(), e);
      end
      stall = (c == 3 || c == 4);
    end
    stall = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    stall = 1'b0;
    tick();
    tick();
    test_reset();
    test_nominal();
    test_k_zero();
    test_max_k();
    test_back_to_back();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
